// File: rtl/rename_nway.sv
// rename_nway: N-wide register rename stage.
//
// Keeps a speculative RAT (updated when a group is accepted), an
// architectural RAT (updated by commits) and a circular free list of
// physical registers. A group of up to LANES instructions is renamed
// all-or-nothing and presented one cycle later in a registered output
// stage. A flush restores SRAT from ARAT and rewinds the free-list read
// pointer so that exactly NF registers are free again.
//
// Ports:
//   CLK, RESET (sync, active-high), FLUSH   clock / reset / recovery
//   in_valid/in_ready, in_lane_v, in_src1, in_src2, in_dst, in_dst_v,
//   in_payload                               rename group input
//   out_valid/out_ready, out_lane_v, out_psrc1, out_psrc2, out_pdst,
//   out_pold, out_dst_v, out_payload         renamed group output
//   cm_valid, cm_arch, cm_pdst, cm_pold      commit lanes
//   free_cnt                                 free physical registers
//   starve_cnt                               cycles stalled on free list
module rename_nway #(
    parameter int LANES      = 2,
    parameter int ARCH_ADDRW = 5,
    parameter int PHYS_ADDRW = 6,
    parameter int PAYLOAD_W  = 64
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            FLUSH,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES-1:0]                in_lane_v,
    input  logic [LANES*ARCH_ADDRW-1:0]     in_src1,
    input  logic [LANES*ARCH_ADDRW-1:0]     in_src2,
    input  logic [LANES*ARCH_ADDRW-1:0]     in_dst,
    input  logic [LANES-1:0]                in_dst_v,
    input  logic [LANES*PAYLOAD_W-1:0]      in_payload,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES-1:0]                out_lane_v,
    output logic [LANES*PHYS_ADDRW-1:0]     out_psrc1,
    output logic [LANES*PHYS_ADDRW-1:0]     out_psrc2,
    output logic [LANES*PHYS_ADDRW-1:0]     out_pdst,
    output logic [LANES*PHYS_ADDRW-1:0]     out_pold,
    output logic [LANES-1:0]                out_dst_v,
    output logic [LANES*PAYLOAD_W-1:0]      out_payload,
    input  logic [LANES-1:0]                cm_valid,
    input  logic [LANES*ARCH_ADDRW-1:0]     cm_arch,
    input  logic [LANES*PHYS_ADDRW-1:0]     cm_pdst,
    input  logic [LANES*PHYS_ADDRW-1:0]     cm_pold,
    output logic [PHYS_ADDRW:0]             free_cnt,
    output logic [31:0]                     starve_cnt
);
    localparam int NA   = 1 << ARCH_ADDRW;
    localparam int NP   = 1 << PHYS_ADDRW;
    localparam int NF   = NP - NA;
    localparam int PTRW = PHYS_ADDRW + 1;

    typedef logic [PHYS_ADDRW-1:0] preg_t;
    typedef logic [PTRW-1:0]       ptr_t;

    preg_t srat   [NA];
    preg_t arat   [NA];
    preg_t arat_n [NA];
    preg_t fl     [NP];
    ptr_t  rd, wr, wr_next, need, pushed;

    // Lane views of the flattened buses (element k == slice k).
    logic [LANES-1:0][ARCH_ADDRW-1:0] src1_a, src2_a, dst_a, cm_arch_a;
    logic [LANES-1:0][PHYS_ADDRW-1:0] cm_pdst_a, cm_pold_a;
    logic [LANES-1:0][PHYS_ADDRW-1:0] psrc1, psrc2, pdst, pold;
    logic [LANES-1:0][PHYS_ADDRW-1:0] o_psrc1, o_psrc2, o_pdst, o_pold;
    logic [LANES-1:0][PHYS_ADDRW-1:0] push_ptr;
    logic [LANES-1:0]                 alloc, push_en;
    logic                             out_free, accept;

    assign src1_a    = in_src1;
    assign src2_a    = in_src2;
    assign dst_a     = in_dst;
    assign cm_arch_a = cm_arch;
    assign cm_pdst_a = cm_pdst;
    assign cm_pold_a = cm_pold;

    assign out_psrc1 = o_psrc1;
    assign out_psrc2 = o_psrc2;
    assign out_pdst  = o_pdst;
    assign out_pold  = o_pold;

    assign free_cnt = wr - rd;
    assign out_free = !out_valid || out_ready;
    assign in_ready = !FLUSH && !RESET && out_free && (free_cnt >= need);
    assign accept   = in_valid && in_ready;

    // Rename: allocating lanes take consecutive entries from rd; sources and
    // old mappings are bypassed from earlier allocating lanes, the highest
    // matching earlier lane winning because it is applied last.
    always_comb begin
        need  = '0;
        alloc = '0;
        pdst  = '0;
        psrc1 = '0;
        psrc2 = '0;
        pold  = '0;
        for (int k = 0; k < LANES; k++) begin
            alloc[k] = in_lane_v[k] && in_dst_v[k] && (dst_a[k] != '0);
            pdst[k]  = fl[PHYS_ADDRW'(rd + need)];
            psrc1[k] = srat[src1_a[k]];
            psrc2[k] = srat[src2_a[k]];
            pold[k]  = srat[dst_a[k]];
            for (int j = 0; j < k; j++) begin
                if (alloc[j]) begin
                    if (dst_a[j] == src1_a[k]) psrc1[k] = pdst[j];
                    if (dst_a[j] == src2_a[k]) psrc2[k] = pdst[j];
                    if (dst_a[j] == dst_a[k])  pold[k]  = pdst[j];
                end
            end
            need = need + PTRW'(alloc[k]);
        end
    end

    // Commit: ARAT updates in lane order and old mappings return to the free
    // list. Arch reg 0 commits neither update nor free anything.
    always_comb begin
        arat_n   = arat;
        pushed   = '0;
        push_en  = '0;
        push_ptr = '0;
        for (int k = 0; k < LANES; k++) begin
            if (cm_valid[k] && cm_arch_a[k] != '0) begin
                arat_n[cm_arch_a[k]] = cm_pdst_a[k];
                push_en[k]  = 1'b1;
                push_ptr[k] = PHYS_ADDRW'(wr + pushed);
                pushed      = pushed + 1'b1;
            end
        end
        wr_next = wr + pushed;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NA; i++) begin
                srat[i] <= preg_t'(i);
                arat[i] <= preg_t'(i);
            end
            for (int i = 0; i < NP; i++)
                fl[i] <= (i < NF) ? preg_t'(NA + i) : '0;
            rd          <= '0;
            wr          <= ptr_t'(NF);
            out_valid   <= 1'b0;
            out_lane_v  <= '0;
            out_dst_v   <= '0;
            o_psrc1     <= '0;
            o_psrc2     <= '0;
            o_pdst      <= '0;
            o_pold      <= '0;
            out_payload <= '0;
            starve_cnt  <= '0;
        end else begin
            arat <= arat_n;
            for (int k = 0; k < LANES; k++)
                if (push_en[k]) fl[push_ptr[k]] <= cm_pold_a[k];
            wr <= wr_next;

            if (FLUSH) begin
                // Everything speculative is discarded; the free list is
                // rewound so it again holds the NF registers not in ARAT.
                srat      <= arat_n;
                rd        <= wr_next - ptr_t'(NF);
                out_valid <= 1'b0;
            end else if (accept) begin
                rd <= rd + need;
                for (int k = 0; k < LANES; k++)
                    if (alloc[k]) srat[dst_a[k]] <= pdst[k];
                out_valid   <= 1'b1;
                out_lane_v  <= in_lane_v;
                out_dst_v   <= alloc;
                out_payload <= in_payload;
                for (int k = 0; k < LANES; k++) begin
                    o_psrc1[k] <= in_lane_v[k] ? psrc1[k] : '0;
                    o_psrc2[k] <= in_lane_v[k] ? psrc2[k] : '0;
                    o_pdst[k]  <= alloc[k] ? pdst[k] : '0;
                    o_pold[k]  <= alloc[k] ? pold[k] : '0;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (in_valid && !FLUSH && out_free && (free_cnt < need) && (starve_cnt != '1))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rename_nway.sv
// tb_rename_nway: directed scoreboard bench for rename_nway (default
// parameters). Stimulus pushes the hand-computed renamed group when the DUT
// accepts it; a monitor pops and compares whenever a group is handed off.
module tb_rename_nway;
    localparam int L  = 2;
    localparam int AW = 5;
    localparam int PW = 6;
    localparam int DW = 64;

    logic              CLK = 1'b0;
    logic              RESET, FLUSH, in_valid, in_ready, out_valid, out_ready;
    logic [L-1:0]      in_lane_v, in_dst_v, out_lane_v, out_dst_v, cm_valid;
    logic [L*AW-1:0]   in_src1, in_src2, in_dst, cm_arch;
    logic [L*DW-1:0]   in_payload, out_payload;
    logic [L*PW-1:0]   out_psrc1, out_psrc2, out_pdst, out_pold, cm_pdst, cm_pold;
    logic [PW:0]       free_cnt;
    logic [31:0]       starve_cnt;

    rename_nway #(.LANES(L), .ARCH_ADDRW(AW), .PHYS_ADDRW(PW), .PAYLOAD_W(DW)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .in_valid(in_valid), .in_ready(in_ready), .in_lane_v(in_lane_v),
        .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst), .in_dst_v(in_dst_v),
        .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_v(out_lane_v),
        .out_psrc1(out_psrc1), .out_psrc2(out_psrc2), .out_pdst(out_pdst),
        .out_pold(out_pold), .out_dst_v(out_dst_v), .out_payload(out_payload),
        .cm_valid(cm_valid), .cm_arch(cm_arch), .cm_pdst(cm_pdst), .cm_pold(cm_pold),
        .free_cnt(free_cnt), .starve_cnt(starve_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [L-1:0]    lane_v;
        logic [L-1:0]    dst_v;
        logic [L*PW-1:0] psrc1, psrc2, pdst, pold;
        logic [L*DW-1:0] payload;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;

    function automatic exp_t mk(input logic [1:0] lv, input logic [1:0] dv,
                                input int a1, input int a2, input int ad, input int ao,
                                input int b1, input int b2, input int bd, input int bo,
                                input int tag);
        exp_t e;
        e.lane_v  = lv;
        e.dst_v   = dv;
        e.psrc1   = {PW'(b1), PW'(a1)};
        e.psrc2   = {PW'(b2), PW'(a2)};
        e.pdst    = {PW'(bd), PW'(ad)};
        e.pold    = {PW'(bo), PW'(ao)};
        e.payload = {64'(tag * 2 + 1), 64'(tag * 2)};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: a group is handed off at the next rising edge.
    always @(negedge CLK) begin
        if (!RESET && out_valid && out_ready) begin
            vectors++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL group: unexpected group pdst=%h", out_pdst);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out_lane_v !== e.lane_v || out_dst_v !== e.dst_v ||
                    out_psrc1 !== e.psrc1 || out_psrc2 !== e.psrc2 ||
                    out_pdst !== e.pdst || out_pold !== e.pold || out_payload !== e.payload) begin
                    errors++;
                    $display("FAIL group (got/exp) lane_v=%b/%b dst_v=%b/%b psrc1=%h/%h psrc2=%h/%h pdst=%h/%h pold=%h/%h payload=%h/%h",
                             out_lane_v, e.lane_v, out_dst_v, e.dst_v, out_psrc1, e.psrc1,
                             out_psrc2, e.psrc2, out_pdst, e.pdst, out_pold, e.pold,
                             out_payload, e.payload);
                end
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_lane(input int k, input logic v, input int s1, input int s2,
                            input int d, input logic dv);
        in_lane_v[k]          = v;
        in_src1[k*AW +: AW]   = AW'(s1);
        in_src2[k*AW +: AW]   = AW'(s2);
        in_dst[k*AW +: AW]    = AW'(d);
        in_dst_v[k]           = dv;
    endtask

    task automatic set_cm(input int k, input logic v, input int a, input int pd, input int po);
        cm_valid[k]          = v;
        cm_arch[k*AW +: AW]  = AW'(a);
        cm_pdst[k*PW +: PW]  = PW'(pd);
        cm_pold[k*PW +: PW]  = PW'(po);
    endtask

    task automatic set_tag(input int tag);
        in_payload = {64'(tag * 2 + 1), 64'(tag * 2)};
    endtask

    // Present the group already on the input pins; record its expected
    // output once the DUT accepts it.
    task automatic send(input exp_t e);
        bit ok = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge CLK);
            if (in_ready) begin
                q.push_back(e);
                ok = 1;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            vectors++;
            errors++;
            $display("FAIL send: group not accepted within 40 cycles");
        end
    endtask

    task automatic do_reset;
        RESET = 1'b1; FLUSH = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_lane_v = '0; in_dst_v = '0; in_src1 = '0; in_src2 = '0; in_dst = '0;
        in_payload = '0; cm_valid = '0; cm_arch = '0; cm_pdst = '0; cm_pold = '0;
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pdst", 64'(out_pdst), 64'd0);
        RESET = 1'b0;
        q.delete();
        #1;
        chk("rst_free_cnt", 64'(free_cnt), 64'd32);
        chk("rst_starve", 64'(starve_cnt), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        do_reset();

        // Basic group with in-group RAW bypass.
        set_lane(0, 1, 1, 2, 3, 1); set_lane(1, 1, 3, 3, 4, 1); set_tag(1);
        send(mk(2'b11, 2'b11, 1, 2, 32, 3, 32, 32, 33, 4, 1));
        chk("basic_free_cnt", 64'(free_cnt), 64'd30);
        set_lane(0, 1, 4, 3, 0, 0); set_lane(1, 0, 0, 0, 0, 0); set_tag(2);
        send(mk(2'b01, 2'b00, 33, 32, 0, 0, 0, 0, 0, 0, 2));

        // WAW inside a group, then read of the winner.
        do_reset();
        set_lane(0, 1, 0, 0, 5, 1); set_lane(1, 1, 0, 0, 5, 1); set_tag(3);
        send(mk(2'b11, 2'b11, 0, 0, 32, 5, 0, 0, 33, 32, 3));
        set_lane(0, 1, 5, 5, 0, 0); set_lane(1, 1, 5, 0, 5, 1); set_tag(4);
        send(mk(2'b11, 2'b10, 33, 33, 0, 0, 33, 0, 34, 33, 4));
        chk("waw_free_cnt", 64'(free_cnt), 64'd29);

        // Destination r0 allocates nothing.
        set_lane(0, 1, 1, 2, 0, 1); set_lane(1, 0, 0, 0, 0, 0); set_tag(5);
        send(mk(2'b01, 2'b00, 1, 2, 0, 0, 0, 0, 0, 0, 5));
        chk("r0_free_cnt", 64'(free_cnt), 64'd29);

        // Output back-pressure: held outputs, no acceptance, no pops.
        do_reset();
        set_lane(0, 1, 1, 2, 9, 1); set_lane(1, 0, 0, 0, 0, 0); set_tag(6);
        send(mk(2'b01, 2'b01, 1, 2, 32, 9, 0, 0, 0, 0, 6));
        out_ready = 1'b0;
        set_lane(0, 1, 9, 0, 10, 1); set_tag(7);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_pdst", 64'(out_pdst), 64'(q[0].pdst));
            chk("stall_psrc1", 64'(out_psrc1), 64'(q[0].psrc1));
            chk("stall_free_cnt", 64'(free_cnt), 64'd31);
            tick();
        end
        out_ready = 1'b1;
        send(mk(2'b01, 2'b01, 32, 0, 33, 10, 0, 0, 0, 0, 7));

        // Reset abandons a group waiting in the output stage.
        out_ready = 1'b0;
        RESET = 1'b1;
        tick();
        chk("reset_abandon_ovld", 64'(out_valid), 64'd0);
        e = q.pop_back();
        do_reset();

        // Rename, partial commit, flush with a same-cycle commit.
        set_lane(0, 1, 0, 0, 3, 1); set_lane(1, 1, 0, 0, 4, 1); set_tag(8);
        send(mk(2'b11, 2'b11, 0, 0, 32, 3, 0, 0, 33, 4, 8));
        set_lane(0, 1, 0, 0, 5, 1); set_lane(1, 1, 0, 0, 6, 1); set_tag(9);
        send(mk(2'b11, 2'b11, 0, 0, 34, 5, 0, 0, 35, 6, 9));
        set_lane(0, 1, 0, 0, 7, 1); set_lane(1, 0, 0, 0, 0, 0); set_tag(10);
        send(mk(2'b01, 2'b01, 0, 0, 36, 7, 0, 0, 0, 0, 10));
        out_ready = 1'b0;
        chk("flush_pre_free", 64'(free_cnt), 64'd27);
        set_cm(0, 1, 3, 32, 3); set_cm(1, 1, 4, 33, 4);
        tick();
        chk("commit_free", 64'(free_cnt), 64'd29);
        set_cm(0, 1, 5, 34, 5); set_cm(1, 0, 0, 0, 0);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0; cm_valid = '0;
        chk("flush_free_cnt", 64'(free_cnt), 64'd32);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        e = q.pop_back();
        out_ready = 1'b1;
        set_lane(0, 1, 3, 5, 6, 1); set_lane(1, 1, 7, 4, 8, 1); set_tag(11);
        send(mk(2'b11, 2'b11, 32, 34, 35, 6, 7, 33, 36, 8, 11));
        chk("post_flush_free", 64'(free_cnt), 64'd30);

        // Drain the free list, starve, then recover from one commit.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_lane(0, 1, 0, 0, 10, 1); set_lane(1, 1, 0, 0, 11, 1); set_tag(20 + i);
            send(mk(2'b11, 2'b11, 0, 0, 32 + 2 * i, (i == 0) ? 10 : 30 + 2 * i,
                    0, 0, 33 + 2 * i, (i == 0) ? 11 : 31 + 2 * i, 20 + i));
        end
        chk("drain_free_cnt", 64'(free_cnt), 64'd0);
        set_lane(0, 1, 0, 0, 10, 1); set_lane(1, 0, 0, 0, 0, 0); set_tag(40);
        in_valid = 1'b1;
        @(negedge CLK);
        chk("starve_in_ready", 64'(in_ready), 64'd0);
        tick(); tick(); tick();
        chk("starve_cnt3", 64'(starve_cnt), 64'd3);
        set_cm(0, 1, 1, 1, 7);
        tick();
        cm_valid = '0;
        chk("starve_cnt4", 64'(starve_cnt), 64'd4);
        chk("refill_free_cnt", 64'(free_cnt), 64'd1);
        send(mk(2'b01, 2'b01, 0, 0, 7, 62, 0, 0, 0, 0, 40));
        chk("refill_free_after", 64'(free_cnt), 64'd0);
        chk("starve_hold", 64'(starve_cnt), 64'd4);

        tick(); tick();
        chk("groups_outstanding", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
